// File: rtl/dac_ad5541a_frame_receiver_if.sv
// dac_ad5541a_frame_receiver_if: serial DAC bus inputs and deserialised word outputs
interface dac_ad5541a_frame_receiver_if #(
    parameter int LANES = 4,
    parameter int WORD_BITS = 16
);
    logic sclk;
    logic [LANES-1:0] cs_n;
    logic [LANES-1:0] sdo;
    logic [LANES*WORD_BITS-1:0] data_out;
    logic [LANES-1:0] data_valid;
    logic [LANES-1:0] frame_err;
    logic [31:0] word_count;
    modport master(output sclk, cs_n, sdo, input data_out, data_valid, frame_err, word_count);
    modport slave(input sclk, cs_n, sdo, output data_out, data_valid, frame_err, word_count);
endinterface

// File: rtl/dac_ad5541a_frame_receiver.sv
// dac_ad5541a_frame_receiver: oversampling deserialiser for multi-lane AD5541A-style DAC frames
module dac_ad5541a_frame_receiver #(
    parameter int LANES = 4,
    parameter int WORD_BITS = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic reset,
    dac_ad5541a_frame_receiver_if.slave bus
);
    localparam int CW = $clog2(WORD_BITS + 2);
    localparam logic [CW-1:0] FULL = CW'(WORD_BITS);
    localparam logic [CW-1:0] SAT = CW'(WORD_BITS + 1);
    typedef enum logic [2:0] {ARM, IDLE, SHIFT, DONE, FAIL} state_t;
    logic [2*LANES:0] sync [SYNC_STAGES];
    logic [2*LANES:0] s;
    logic sclk_prev, sclk_rise;
    logic [LANES-1:0] cs_prev, cs_rise, cs_fall, cs_q, sdo_q, done, fail, valid, err;
    logic [31:0] wc;
    assign s = sync[SYNC_STAGES-1];
    // edge pulses are registered together with cs/sdo so all lane inputs stay cycle-aligned
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '{default: '0};
            sclk_prev <= 1'b0;
            sclk_rise <= 1'b0;
            cs_prev <= '0;
            cs_rise <= '0;
            cs_fall <= '0;
            cs_q <= '0;
            sdo_q <= '0;
            valid <= '0;
            err <= '0;
            wc <= '0;
        end else begin
            sync[0] <= {bus.sclk, bus.cs_n, bus.sdo};
            for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
            sclk_prev <= s[2*LANES];
            cs_prev <= s[2*LANES-1:LANES];
            sclk_rise <= s[2*LANES] & ~sclk_prev;
            cs_rise <= s[2*LANES-1:LANES] & ~cs_prev;
            cs_fall <= ~s[2*LANES-1:LANES] & cs_prev;
            cs_q <= s[2*LANES-1:LANES];
            sdo_q <= s[LANES-1:0];
            valid <= done;
            err <= fail;
            wc <= wc + 32'($countones(done));
        end
    end
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        state_t st, nx;
        logic [WORD_BITS-1:0] sr, word;
        logic [CW-1:0] cnt;
        always_ff @(posedge clk) begin
            if (reset) begin
                st <= ARM;
                sr <= '0;
                cnt <= '0;
                word <= '0;
            end else begin
                st <= nx;
                if (st == DONE) word <= sr;
                if (cs_fall[i] && st != ARM && st != SHIFT) begin
                    sr <= '0;
                    cnt <= '0;
                end else if (st == SHIFT && sclk_rise && !cs_q[i]) begin
                    sr <= {sr[WORD_BITS-2:0], sdo_q[i]};
                    cnt <= cnt == SAT ? cnt : cnt + 1'b1;
                end
            end
        end
        // DONE/FAIL last one cycle and behave like IDLE so a quick next frame is not lost
        always_comb begin
            nx = st;
            if (st == ARM) nx = cs_q[i] ? IDLE : ARM;
            else if (st == SHIFT) nx = cs_rise[i] ? (cnt == FULL ? DONE : FAIL) : SHIFT;
            else nx = cs_fall[i] ? SHIFT : IDLE;
        end
        assign done[i] = st == DONE;
        assign fail[i] = st == FAIL;
        assign bus.data_out[i*WORD_BITS +: WORD_BITS] = word;
    end
    assign bus.data_valid = valid;
    assign bus.frame_err = err;
    assign bus.word_count = wc;
endmodule

// File: tb/tb_dac_ad5541a_frame_receiver.sv
// tb_dac_ad5541a_frame_receiver: directed scenario tests for the DAC frame receiver
module tb_dac_ad5541a_frame_receiver;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    int vcount [4];
    int ecount [4];
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    dac_ad5541a_frame_receiver_if #(.LANES(4), .WORD_BITS(16)) bus ();

    dac_ad5541a_frame_receiver dut (.clk(clk), .reset(reset), .bus(bus));

    always @(negedge clk)
        for (int l = 0; l < 4; l++) begin
            vcount[l] += int'(bus.data_valid[l]);
            ecount[l] += int'(bus.frame_err[l]);
        end

    function automatic int vsum();
        return vcount[0] + vcount[1] + vcount[2] + vcount[3];
    endfunction

    function automatic int esum();
        return ecount[0] + ecount[1] + ecount[2] + ecount[3];
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sbit(input logic [3:0] v, input int half);
        bus.sdo = v;
        cyc(half);
        bus.sclk = 1'b1;
        cyc(half);
        bus.sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] ln, input logic [63:0] w, input int nbits,
                              input int half, input bit lead, input bit trail);
        logic [3:0] v;
        int idx;
        if (lead) begin
            bus.sdo = ln;
            bus.sclk = 1'b1;
            bus.cs_n = ~ln;
            cyc(half);
            bus.sclk = 1'b0;
        end else bus.cs_n = ~ln;
        for (int b = 0; b < nbits; b++) begin
            idx = nbits - 1 - b;
            for (int l = 0; l < 4; l++) v[l] = idx < 16 ? w[l*16+idx] : 1'b0;
            sbit(v, half);
        end
        cyc(half);
        if (trail) bus.sclk = 1'b1;
        bus.cs_n = '1;
    endtask

    task automatic test_reset();
        bus.sclk = 1'b0;
        bus.cs_n = '1;
        bus.sdo = '0;
        reset = 1'b1;
        cyc(3);
        checks++;
        if (bus.data_out !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected %h", bus.data_out, 64'h0);
        end
        checks++;
        if ({bus.data_valid, bus.frame_err, bus.word_count} !== 40'h0) begin
            errors++;
            $display("FAIL reset_flags: got %h/%h/%h expected 0/0/0", bus.data_valid, bus.frame_err, bus.word_count);
        end
        reset = 1'b0;
        cyc(6);
    endtask

    task automatic test_good_frame();
        send_frame(4'b0001, 64'h0000_0000_0000_A55A, 16, 10, 0, 0);
        cyc(4);
        checks++;
        if (bus.data_valid !== 4'b0000) begin
            errors++;
            $display("FAIL good_early_valid: got %b expected %b", bus.data_valid, 4'b0000);
        end
        cyc(1);
        checks++;
        if ({bus.data_valid, bus.frame_err} !== 8'b0001_0000) begin
            errors++;
            $display("FAIL good_valid: got %b/%b expected 0001/0000", bus.data_valid, bus.frame_err);
        end
        checks++;
        if (bus.data_out[15:0] !== 16'hA55A || bus.word_count !== 32'd1) begin
            errors++;
            $display("FAIL good_data: got %h wc %0d expected a55a wc 1", bus.data_out[15:0], bus.word_count);
        end
        cyc(1);
        checks++;
        if (bus.data_valid !== 4'b0000) begin
            errors++;
            $display("FAIL good_pulse_width: got %b expected %b", bus.data_valid, 4'b0000);
        end
        cyc(4);
    endtask

    task automatic test_all_lanes();
        send_frame(4'b1111, 64'h0000_FFFF_1234_8000, 16, 4, 0, 0);
        cyc(5);
        checks++;
        if ({bus.data_valid, bus.frame_err} !== 8'b1111_0000) begin
            errors++;
            $display("FAIL all_valid: got %b/%b expected 1111/0000", bus.data_valid, bus.frame_err);
        end
        checks++;
        if (bus.data_out !== 64'h0000_FFFF_1234_8000) begin
            errors++;
            $display("FAIL all_data: got %h expected %h", bus.data_out, 64'h0000_FFFF_1234_8000);
        end
        checks++;
        if (bus.word_count !== 32'd5) begin
            errors++;
            $display("FAIL all_count: got %0d expected 5", bus.word_count);
        end
        cyc(4);
    endtask

    task automatic test_short_long();
        for (int n = 15; n <= 17; n += 2) begin
            send_frame(4'b0100, 64'h0000_ABCD_0000_0000, n, 4, 0, 0);
            cyc(5);
            checks++;
            if ({bus.data_valid, bus.frame_err} !== 8'b0000_0100) begin
                errors++;
                $display("FAIL bits%0d_err: got %b/%b expected 0000/0100", n, bus.data_valid, bus.frame_err);
            end
            cyc(4);
        end
        checks++;
        if (bus.data_out[47:32] !== 16'hFFFF || bus.word_count !== 32'd5) begin
            errors++;
            $display("FAIL short_long_keep: got %h wc %0d expected ffff wc 5", bus.data_out[47:32], bus.word_count);
        end
    endtask

    task automatic test_zero_bit();
        send_frame(4'b0001, 64'h0, 0, 4, 0, 0);
        cyc(5);
        checks++;
        if ({bus.data_valid, bus.frame_err} !== 8'b0000_0001) begin
            errors++;
            $display("FAIL zero_bit_err: got %b/%b expected 0000/0001", bus.data_valid, bus.frame_err);
        end
        checks++;
        if (bus.data_out !== 64'h0000_FFFF_1234_8000) begin
            errors++;
            $display("FAIL zero_bit_keep: got %h expected %h", bus.data_out, 64'h0000_FFFF_1234_8000);
        end
        cyc(4);
    endtask

    task automatic test_edge_coincide();
        send_frame(4'b1000, 64'hC3A5_0000_0000_0000, 16, 4, 1, 0);
        cyc(5);
        checks++;
        if ({bus.data_valid, bus.frame_err} !== 8'b1000_0000 || bus.data_out[63:48] !== 16'hC3A5) begin
            errors++;
            $display("FAIL edge_lead: got %b/%b %h expected 1000/0000 c3a5", bus.data_valid, bus.frame_err, bus.data_out[63:48]);
        end
        cyc(4);
        send_frame(4'b1000, 64'h5A3C_0000_0000_0000, 16, 4, 0, 1);
        cyc(5);
        checks++;
        if ({bus.data_valid, bus.frame_err} !== 8'b1000_0000 || bus.data_out[63:48] !== 16'h5A3C) begin
            errors++;
            $display("FAIL edge_trail: got %b/%b %h expected 1000/0000 5a3c", bus.data_valid, bus.frame_err, bus.data_out[63:48]);
        end
        checks++;
        if (bus.word_count !== 32'd7) begin
            errors++;
            $display("FAIL edge_count: got %0d expected 7", bus.word_count);
        end
        bus.sclk = 1'b0;
        cyc(4);
    endtask

    task automatic test_reset_mid();
        int v0, e0;
        bus.cs_n = 4'b1101;
        for (int b = 0; b < 8; b++) sbit(4'b0010, 4);
        reset = 1'b1;
        cyc(2);
        checks++;
        if ({bus.data_out, bus.data_valid, bus.frame_err, bus.word_count} !== 104'h0) begin
            errors++;
            $display("FAIL reset_mid_clear: got %h/%b/%b/%0d expected all zero", bus.data_out, bus.data_valid, bus.frame_err, bus.word_count);
        end
        reset = 1'b0;
        v0 = vsum();
        e0 = esum();
        for (int b = 0; b < 8; b++) sbit(4'b0000, 4);
        cyc(4);
        bus.cs_n = '1;
        cyc(10);
        checks++;
        if (vsum() != v0 || esum() != e0) begin
            errors++;
            $display("FAIL reset_mid_silent: got %0d valid %0d err expected 0 0", vsum() - v0, esum() - e0);
        end
        send_frame(4'b0010, 64'h0000_0000_00FF_0000, 16, 4, 0, 0);
        cyc(5);
        checks++;
        if (bus.data_out !== 64'h0000_0000_00FF_0000 || bus.data_valid !== 4'b0010 || bus.word_count !== 32'd1) begin
            errors++;
            $display("FAIL reset_mid_next: got %h/%b/%0d expected 00ff0000/0010/1", bus.data_out, bus.data_valid, bus.word_count);
        end
        cyc(4);
    endtask

    task automatic test_max_rate();
        int e0;
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(6);
        e0 = esum();
        exp_q.delete();
        fork
            begin
                logic [63:0] w;
                for (int n = 0; n < 1000; n++) begin
                    w = {$urandom, $urandom};
                    exp_q.push_back(w);
                    send_frame(4'b1111, w, 16, 2, 0, 0);
                    cyc(3);
                end
            end
            begin
                int got = 0;
                for (int c = 0; c < 80000 && got < 1000; c++) begin
                    @(negedge clk);
                    if (bus.data_valid !== 4'b0000) begin
                        checks++;
                        if (bus.data_valid !== 4'b1111 || exp_q.size() == 0 || bus.data_out !== exp_q[0]) begin
                            errors++;
                            $display("FAIL max_rate_word%0d: got %b %h expected 1111 %h", got, bus.data_valid, bus.data_out, exp_q.size() ? exp_q[0] : 64'h0);
                        end
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        got++;
                    end
                end
                checks++;
                if (got != 1000) begin
                    errors++;
                    $display("FAIL max_rate_timeout: got %0d words expected 1000", got);
                end
            end
        join
        cyc(6);
        checks++;
        if (bus.word_count !== 32'd4000 || esum() != e0) begin
            errors++;
            $display("FAIL max_rate_count: got %0d wc %0d err expected 4000 0", bus.word_count, esum() - e0);
        end
    endtask

    task automatic test_wrap();
        force dut.wc = 32'hFFFF_FFFF;
        cyc(1);
        release dut.wc;
        cyc(1);
        send_frame(4'b0001, 64'h0000_0000_0000_0001, 16, 4, 0, 0);
        cyc(5);
        checks++;
        if (bus.word_count !== 32'h0 || bus.data_valid !== 4'b0001) begin
            errors++;
            $display("FAIL wrap: got %h/%b expected 00000000/0001", bus.word_count, bus.data_valid);
        end
        cyc(4);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_good_frame();
        test_all_lanes();
        test_short_long();
        test_zero_bit();
        test_edge_coincide();
        test_reset_mid();
        test_max_rate();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
